// File: rtl/asg_burst_seq.sv
// Burst sequence scheduler for one ASG channel: walks a descriptor table,
// loads each burst configuration, triggers the ASG and waits for its stop.
module asg_burst_seq #(
   parameter int unsigned TN  = 1,
   parameter int unsigned CWM = 14,
   parameter int unsigned CWF = 16,
   parameter int unsigned CWL = 32,
   parameter int unsigned CWN = 16,
   parameter int unsigned SN  = 8,
   parameter int unsigned SW  = $clog2(SN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tbl_wen,
   input  logic [SW-1:0]        tbl_adr,
   input  logic [CWM+CWF-1:0]   tbl_off,
   input  logic [CWM-1:0]       tbl_bdl,
   input  logic [CWL-1:0]       tbl_bln,
   input  logic [CWN-1:0]       tbl_bnm,
   input  logic [CWL-1:0]       tbl_dly,
   input  logic                 ctl_str,
   input  logic                 ctl_stp,
   input  logic [SW-1:0]        cfg_len,
   input  logic [CWN-1:0]       cfg_lpn,
   input  logic                 cfg_inf,
   output logic                 asg_rst,
   output logic [TN-1:0]        asg_trg,
   output logic [CWM+CWF-1:0]   asg_off,
   output logic [CWM-1:0]       asg_bdl,
   output logic [CWL-1:0]       asg_bln,
   output logic [CWN-1:0]       asg_bnm,
   input  logic                 asg_stp,
   output logic                 sts_run,
   output logic [SW-1:0]        sts_idx,
   output logic [CWN-1:0]       sts_lpc,
   output logic                 irq_end
);

   typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT, GAP} state_t;

   state_t              state;
   logic [CWM+CWF-1:0]  t_off [SN];
   logic [CWM-1:0]      t_bdl [SN];
   logic [CWL-1:0]      t_bln [SN];
   logic [CWN-1:0]      t_bnm [SN];
   logic [CWL-1:0]      t_dly [SN];
   logic [CWL-1:0]      gap_cnt;
   logic                fin;

   always_ff @(posedge clk) begin
      if (tbl_wen) begin
         t_off[tbl_adr] <= tbl_off;
         t_bdl[tbl_adr] <= tbl_bdl;
         t_bln[tbl_adr] <= tbl_bln;
         t_bnm[tbl_adr] <= tbl_bnm;
         t_dly[tbl_adr] <= tbl_dly;
      end
   end

   // Burst finished: stop seen with no gap, or last gap cycle reached.
   always_comb begin
      fin = 1'b0;
      case (state)
         WAIT:    fin = asg_stp && (gap_cnt == '0);
         GAP:     fin = (gap_cnt == CWL'(1));
         default: fin = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         asg_rst <= 1'b0;
         asg_trg <= '0;
         asg_off <= '0;
         asg_bdl <= '0;
         asg_bln <= '0;
         asg_bnm <= '0;
         sts_run <= 1'b0;
         sts_idx <= '0;
         sts_lpc <= '0;
         irq_end <= 1'b0;
         gap_cnt <= '0;
      end else begin
         asg_rst <= 1'b0;
         asg_trg <= '0;
         irq_end <= 1'b0;
         if (ctl_stp) begin
            asg_rst <= 1'b1;
            sts_run <= 1'b0;
            gap_cnt <= '0;
            state   <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (ctl_str) begin
                     sts_idx <= '0;
                     sts_lpc <= '0;
                     sts_run <= 1'b1;
                     state   <= LOAD;
                  end
               end
               LOAD: begin
                  asg_off <= t_off[sts_idx];
                  asg_bdl <= t_bdl[sts_idx];
                  asg_bln <= t_bln[sts_idx];
                  asg_bnm <= t_bnm[sts_idx];
                  gap_cnt <= t_dly[sts_idx];
                  asg_trg <= '1;
                  state   <= TRIG;
               end
               TRIG: state <= WAIT;
               WAIT: begin
                  if (asg_stp && (gap_cnt != '0)) state <= GAP;
               end
               GAP: gap_cnt <= gap_cnt - CWL'(1);
               default: state <= IDLE;
            endcase
            // Shared advance step for both WAIT and GAP exits; overrides the case above.
            if (fin) begin
               if (sts_idx < cfg_len) begin
                  sts_idx <= sts_idx + SW'(1);
                  state   <= LOAD;
               end else if (cfg_inf || (sts_lpc < cfg_lpn)) begin
                  sts_idx <= '0;
                  if (sts_lpc != '1) sts_lpc <= sts_lpc + CWN'(1);
                  state   <= LOAD;
               end else begin
                  sts_run <= 1'b0;
                  irq_end <= 1'b1;
                  state   <= IDLE;
               end
            end
         end
      end
   end

endmodule
